// File: rtl/sound_frame_seq.sv
// Frame sequencer: freq-base strobe plus 256/128/64 Hz length/sweep/envelope strobes.
// Define SOUND_EXT_DIV_EN to step on falling edges of div_bit instead of the internal prescaler.
module sound_frame_seq #(
  parameter int FREQ_DIV = 2,
  parameter int STEP_DIV = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master_enable,
  input  logic       div_reset,
  input  logic       div_bit,
  output logic       clk_freq_div,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [2:0] step
);

  localparam int FW = $clog2(FREQ_DIV);
  localparam logic [FW-1:0] FREQ_LAST = FW'(FREQ_DIV - 1);

  logic [FW-1:0] freq_cnt;
  logic          freq_last;
  logic          step_tick;

  assign freq_last = (freq_cnt == FREQ_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_cnt     <= '0;
      clk_freq_div <= 1'b0;
    end else if (!master_enable) begin
      freq_cnt     <= '0;
      clk_freq_div <= 1'b0;
    end else begin
      freq_cnt     <= freq_last ? '0 : freq_cnt + 1'b1;
      clk_freq_div <= freq_last;
    end
  end

`ifdef SOUND_EXT_DIV_EN
  logic div_prev;
  logic unused;

  // div_reset has no meaning when the DIV tap comes from outside.
  assign unused = div_reset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= div_bit;
    end
  end

  assign step_tick = master_enable & div_prev & ~div_bit;
`else
  localparam int SW = $clog2(STEP_DIV);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  logic [SW-1:0] step_cnt;
  logic          unused;

  assign unused = div_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (!master_enable || div_reset || step_cnt == STEP_LAST) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // A coinciding DIV write restarts the prescaler and swallows the tick.
  assign step_tick = master_enable & ~div_reset & (step_cnt == STEP_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step           <= 3'd0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else if (!master_enable) begin
      step           <= 3'd0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      clk_length_ctr <= step_tick & ~step[0];
      clk_sweep      <= step_tick & (step[1:0] == 2'b10);
      clk_vol_env    <= step_tick & (step == 3'd7);
      if (step_tick) begin
        step <= step + 3'd1;
      end
    end
  end

endmodule
